// File: rtl/beep_melody_player_if.sv
// Host-side bundle for the melody player: note RAM writes, playback control
// and the buzzer/status outputs.
interface beep_melody_player_if #(
  parameter int AW       = 5,
  parameter int PERIOD_W = 18,
  parameter int BEAT_W   = 4
);
  logic                       wr_en;
  logic [AW-1:0]              wr_addr;
  logic [PERIOD_W+BEAT_W-1:0] wr_data;
  logic [AW:0]                song_len;
  logic                       start;
  logic                       stop;
  logic                       loop;
  logic [1:0]                 vol;
  logic                       beep;
  logic                       busy;
  logic                       done;
  logic [AW-1:0]              note_idx;

  modport master (
    output wr_en, wr_addr, wr_data, song_len, start, stop, loop, vol,
    input  beep, busy, done, note_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, song_len, start, stop, loop, vol,
    output beep, busy, done, note_idx
  );
endinterface

// File: rtl/beep_melody_player.sv
// Programmable buzzer melody player: plays {period, beats} entries from a
// writable note RAM with duty/volume select, articulation gap, loop and stop.
module beep_melody_player #(
  parameter int AW          = 5,
  parameter int PERIOD_W    = 18,
  parameter int BEAT_W      = 4,
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  beep_melody_player_if.slave  bus
);
  localparam int          DW     = PERIOD_W + BEAT_W;
  localparam logic [31:0] UNIT_U = 32'(UNIT_CYCLES);
  localparam logic [31:0] GAP_U  = 32'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       mem_q [2**AW];
  logic [DW-1:0]       rd_data;
  logic [AW:0]         len_q, len_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_freq_q, cnt_freq_d;
  logic [PERIOD_W-1:0] th;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [31:0]         dur_q, dur_d;
  logic [31:0]         gap_q, gap_d;
  logic                beep_q, beep_d;
  logic                done_q, done_d;
  logic                play_last, gap_last, song_last, advance;

  // Note RAM is never reset; writes land in any state and only become
  // audible when the entry is next fetched into period_q/beats_q.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
  end

  assign rd_data   = mem_q[idx_q];
  assign play_last = (dur_q == (32'(beats_q) * UNIT_U) - 32'd1);
  assign gap_last  = (gap_q == GAP_U - 32'd1);
  assign song_last = ({1'b0, idx_q} == len_q - (AW+1)'(1));

  always_comb begin
    case (bus.vol)
      2'd0:    th = period_q >> 1;
      2'd1:    th = period_q >> 2;
      default: th = period_q >> 3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    period_d   = period_q;
    beats_d    = beats_q;
    cnt_freq_d = cnt_freq_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    beep_d     = 1'b0;
    done_d     = 1'b0;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && bus.song_len != '0) begin
          len_d   = bus.song_len;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        period_d   = rd_data[DW-1:BEAT_W];
        beats_d    = (rd_data[BEAT_W-1:0] == '0) ? BEAT_W'(1) : rd_data[BEAT_W-1:0];
        cnt_freq_d = '0;
        dur_d      = '0;
        state_d    = PLAY;
      end
      PLAY: begin
        cnt_freq_d = (period_q == '0 || cnt_freq_q == period_q - PERIOD_W'(1))
                     ? '0 : cnt_freq_q + PERIOD_W'(1);
        dur_d      = dur_q + 32'd1;
        // Forcing beep low on the last cycle keeps the lagged output silent
        // through the gap (or the next FETCH when there is no gap).
        if (play_last) begin
          if (GAP_CYCLES == 0) begin
            advance = 1'b1;
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end else begin
          beep_d = (cnt_freq_q < th) && (period_q != '0) && (bus.vol != 2'd3);
        end
      end
      GAP: begin
        gap_d = gap_q + 32'd1;
        if (gap_last) advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (!song_last) begin
        idx_d   = idx_q + AW'(1);
        state_d = FETCH;
      end else if (bus.loop) begin
        idx_d   = '0;
        state_d = FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    if (bus.stop) begin
      state_d = IDLE;
      beep_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      period_q   <= '0;
      beats_q    <= '0;
      cnt_freq_q <= '0;
      dur_q      <= '0;
      gap_q      <= '0;
      beep_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      period_q   <= period_d;
      beats_q    <= beats_d;
      cnt_freq_q <= cnt_freq_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      beep_q     <= beep_d;
      done_q     <= done_d;
    end
  end

  assign bus.beep     = beep_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.note_idx = idx_q;
endmodule

// File: tb/tb_beep_melody_player.sv
// Scoreboard bench for beep_melody_player: per-cycle expected outputs are
// queued when a song is launched and popped against the DUT each cycle.
module tb_beep_melody_player;
  localparam int AW = 3, PW = 18, BW = 4, UNIT = 10, GAPC = 2;

  typedef struct packed {
    logic          beep;
    logic          busy;
    logic          done;
    logic [AW-1:0] idx;
  } obs_t;

  logic clk, rst_n;
  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  beep_melody_player_if #(.AW(AW), .PERIOD_W(PW), .BEAT_W(BW)) bus();

  beep_melody_player #(
    .AW(AW), .PERIOD_W(PW), .BEAT_W(BW), .UNIT_CYCLES(UNIT), .GAP_CYCLES(GAPC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(bit be, bit bu, bit d, int i);
    obs_t o;
    o = {be, bu, d, AW'(i)};
    return o;
  endfunction

  // Expected trace of one note: FETCH, beats*UNIT PLAY cycles with beep
  // lagging the tone counter by one cycle, then the silent gap.
  task automatic push_note(int p, int b, int idx, int v);
    int be, th;
    bit hi;
    be = (b == 0) ? 1 : b;
    th = (v == 0) ? (p >> 1) : (v == 1) ? (p >> 2) : (p >> 3);
    exp_q.push_back(mk(0, 1, 0, idx));
    for (int k = 1; k <= be * UNIT; k++) begin
      hi = 1'b0;
      if (k >= 2 && p != 0 && v != 3) hi = (((k - 2) % p) < th);
      exp_q.push_back(mk(hi, 1, 0, idx));
    end
    for (int k = 0; k < GAPC; k++) exp_q.push_back(mk(0, 1, 0, idx));
  endtask

  task automatic push_idle(int idx, bit d);
    exp_q.push_back(mk(0, 0, d, idx));
  endtask

  task automatic wr(int addr, int p, int b);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = {PW'(p), BW'(b)};
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic go(int len, int v, bit lp);
    bus.song_len = (AW+1)'(len);
    bus.vol      = 2'(v);
    bus.loop     = lp;
    bus.start    = 1'b1;
  endtask

  // Pops one expectation per cycle; after the act_at-th compare applies an
  // action: 1 drop loop, 2 pulse stop, 3 rewrite entry1, 4 pulse start.
  task automatic run_trace(string name, int act_at, int act);
    obs_t got, exp;
    int   n;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {bus.beep, bus.busy, bus.done, bus.note_idx};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cyc %0d: got beep=%b busy=%b done=%b idx=%0d, want beep=%b busy=%b done=%b idx=%0d",
                 name, n, got.beep, got.busy, got.done, got.idx,
                 exp.beep, exp.busy, exp.done, exp.idx);
      end
      n++;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.wr_en = 1'b0;
      if (n == act_at) begin
        case (act)
          1: bus.loop = 1'b0;
          2: bus.stop = 1'b1;
          3: begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(1);
            bus.wr_data = {PW'(6), BW'(1)};
          end
          4: begin
            bus.start    = 1'b1;
            bus.song_len = (AW+1)'(2);
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic test_reset();
    obs_t got;
    @(negedge clk);
    @(negedge clk);
    got = {bus.beep, bus.busy, bus.done, bus.note_idx};
    n_vec++;
    if (got !== mk(0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL reset_state: got %b, want %b", got, mk(0, 0, 0, 0));
    end
    rst_n = 1'b1;
    push_idle(0, 0);
    push_idle(0, 0);
    run_trace("idle_after_reset", 0, 0);
  endtask

  task automatic test_duty();
    wr(0, 8, 2);
    for (int v = 0; v < 4; v++) begin
      push_note(8, 2, 0, v);
      push_idle(0, 1);
      push_idle(0, 0);
      go(1, v, 0);
      run_trace($sformatf("duty_vol%0d", v), 0, 0);
    end
  endtask

  task automatic test_collisions();
    bus.stop = 1'b1;
    go(1, 0, 0);
    for (int i = 0; i < 3; i++) push_idle(0, 0);
    run_trace("start_stop_idle", 0, 0);

    push_note(8, 2, 0, 0);
    push_idle(0, 1);
    push_idle(0, 0);
    go(1, 0, 0);
    run_trace("start_while_busy", 5, 4);

    push_note(8, 2, 0, 0);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    for (int i = 0; i < 4; i++) push_idle(0, 0);
    go(1, 0, 0);
    run_trace("stop_mid_play", 6, 2);
  endtask

  task automatic test_rest_beats0();
    wr(0, 0, 3);
    wr(1, 8, 0);
    push_note(0, 3, 0, 0);
    push_note(8, 0, 1, 0);
    push_idle(1, 1);
    push_idle(1, 0);
    go(2, 0, 0);
    run_trace("rest_beats0", 0, 0);
  endtask

  task automatic test_loop();
    wr(0, 4, 1);
    wr(1, 6, 1);
    push_note(4, 1, 0, 0);
    push_note(6, 1, 1, 0);
    push_note(4, 1, 0, 0);
    push_note(6, 1, 1, 0);
    push_idle(1, 1);
    push_idle(1, 0);
    go(2, 0, 1);
    run_trace("loop_wrap", 30, 1);
  endtask

  task automatic test_write_while_playing();
    wr(0, 8, 1);
    wr(1, 4, 2);
    push_note(8, 1, 0, 0);
    push_note(6, 1, 1, 0);
    push_idle(1, 1);
    push_idle(1, 0);
    go(2, 0, 0);
    run_trace("write_while_playing", 3, 3);
  endtask

  task automatic test_reset_mid_play();
    obs_t got;
    wr(0, 8, 2);
    push_note(8, 2, 0, 0);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    go(1, 0, 0);
    run_trace("pre_reset_play", 0, 0);
    rst_n = 1'b0;
    #1;
    got = {bus.beep, bus.busy, bus.done, bus.note_idx};
    n_vec++;
    if (got !== mk(0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL async_reset_mid_play: got %b, want %b", got, mk(0, 0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(0, 0);
    push_idle(0, 0);
    run_trace("after_mid_reset", 0, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.song_len = '0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop     = 1'b0;
    bus.vol      = 2'd0;
    test_reset();
    test_duty();
    test_collisions();
    test_rest_beats0();
    test_loop();
    test_write_while_playing();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/beep_melody_player.md
Name: beep_melody_player

Overview:
- Parametrised, programmable successor to the fixed-song buzzer player; plays a melody from a writable note RAM on a passive buzzer.
- Each note entry holds a tone half-period count and a length in beat units. Period 0 denotes a rest.
- Adds runtime song length, loop mode, a volume (duty) select, an inter-note articulation gap, start/stop control and a done pulse.
- Sits between a host register interface and the buzzer pin.

Parameters:
- AW, 5: note RAM address width; depth = 2**AW entries.
- PERIOD_W, 18: tone period counter width, in clk cycles per full tone period.
- BEAT_W, 4: note length field width, in beats.
- UNIT_CYCLES, 12_500_000: clk cycles per beat (250 ms at 50 MHz); timer width is 32 bits.
- GAP_CYCLES, 500_000: silent cycles after each note; 0 means no gap.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low; clock clk.
- wr_en, in, 1: note RAM write strobe.
- wr_addr, in, AW: note RAM write address.
- wr_data, in, PERIOD_W+BEAT_W: {period, beats}.
- song_len, in, AW+1: number of notes, 1..2**AW; sampled on start.
- start, in, 1: single-cycle play request.
- stop, in, 1: abort request.
- loop, in, 1: repeat the song; sampled live at end of each pass.
- vol, in, 2: duty select. 0 = 50 %, 1 = 25 %, 2 = 12.5 %, 3 = mute.
- beep, out, 1: buzzer drive.
- busy, out, 1: high in any non-IDLE state.
- done, out, 1: one-cycle pulse on natural completion.
- note_idx, out, AW: index of the current note.

Behaviour:
- Reset values: beep=0, busy=0, done=0, note_idx=0, state=IDLE, all counters 0. The note RAM is not cleared.
- RAM writes:
  - Synchronous, accepted in every state.
  - A write to the entry currently playing has no effect until that entry is next fetched.
- State machine: IDLE -> FETCH -> PLAY -> GAP -> FETCH/IDLE.
- IDLE:
  - On start with song_len != 0, latch len = song_len, set idx = 0 and go to FETCH.
  - start with song_len == 0 is ignored.
- FETCH (1 cycle):
  - Registered RAM read at idx; latch period and beats. beats == 0 is treated as 1.
  - Clear the tone and duration counters; go to PLAY.
- PLAY:
  - Lasts exactly beats*UNIT_CYCLES cycles.
  - cnt_freq counts 0..period-1, then wraps.
  - High threshold th = period>>1, period>>2 or period>>3 according to vol.
  - beep(next) = (cnt_freq < th) && period != 0 && vol != 3.
  - On the last duration cycle, go to GAP, or straight to FETCH/end if GAP_CYCLES == 0.
- GAP:
  - beep = 0 for GAP_CYCLES cycles.
  - Then, if idx == len-1: when loop = 1, set idx = 0 and go to FETCH; otherwise pulse done and go to IDLE.
  - Otherwise idx++ and go to FETCH.
- Output timing: beep is registered and lags cnt_freq by one cycle; it is 0 in IDLE, FETCH and GAP.
- stop:
  - Has priority over every transition; takes effect in any state.
  - Next cycle: state = IDLE, beep = 0, busy = 0, no done pulse.
  - stop and start in the same cycle: stop wins; the player stays or returns to IDLE.
- start while busy is ignored; a song is never restarted mid-play.
- Changing vol mid-note takes effect on the next cycle. Changing song_len mid-play has no effect.
- note_idx mirrors idx.
- Reset mid-play returns everything to its reset values immediately (asynchronous).

Test Plan:
- Bench parameters for all scenarios: UNIT_CYCLES=10, GAP_CYCLES=2, AW=3.
- 50 % tone: entry0={period 8, beats 2}, song_len=1, vol=0, start.
  - FETCH 1 cycle, then PLAY 20 cycles with beep pattern 4 high / 4 low.
  - GAP 2 cycles, then done pulses once and busy falls; 23 busy cycles in total.
- Duty and mute: repeat with vol=1, 2 and 3.
  - Required: 2 high / 6 low, 1 high / 7 low, and beep constantly 0.
- Rest and beats=0: entries {0,3}, {8,0}, song_len=2.
  - Required: 30 silent PLAY cycles, then a 10-cycle tone; note_idx goes 0 then 1.
- Loop: 2-note song with loop=1.
  - Required: idx wraps 1 -> 0 with no IDLE cycle and no done pulse.
  - Drop loop during the second pass; required: done after that pass ends.
- Stop and start collisions:
  - stop mid-PLAY: required beep=0 and busy=0 the next cycle, no done.
  - start+stop in the same cycle from IDLE: required to remain IDLE.
  - start while busy: required to have no effect.
- Write while playing and reset:
  - Overwrite entry1 during note0; required: the new value plays.
  - Assert rst_n low mid-PLAY; required: all outputs 0 asynchronously.
